// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector with KMP transitions and runtime overlap mode.
// Build macro SEQDET_MATCH_CNT_EN enables the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detect_param #(
   parameter int unsigned       PAT_W   = 4,
   parameter logic [PAT_W-1:0]  PATTERN = 4'b1101,
   parameter int unsigned       CNT_W   = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             in_valid,
   input  logic             in,
   input  logic             overlap,
   input  logic             clr,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int unsigned SW = $clog2(PAT_W + 1);

   function automatic logic pat_bit(input int unsigned i);
      return PATTERN[PAT_W-1-i];
   endfunction

   // Length of the longest pattern prefix that is a suffix of (first k pattern bits, then b).
   function automatic int unsigned ext_len(input int unsigned k, input logic b);
      logic [16:0] seq;
      logic        ok;
      seq    = '0;
      for (int unsigned i = 0; i < k; i++) seq[i] = pat_bit(i);
      seq[k] = b;
      for (int unsigned len = k + 1; len > 0; len--) begin
         ok = 1'b1;
         for (int unsigned j = 0; j < len; j++)
            if (seq[k + 1 - len + j] != pat_bit(j)) ok = 1'b0;
         if (ok) return len;
      end
      return 0;
   endfunction

   // Longest proper border of the whole pattern: the resume state after an overlapping match.
   function automatic int unsigned border_len();
      logic ok;
      for (int unsigned len = PAT_W - 1; len > 0; len--) begin
         ok = 1'b1;
         for (int unsigned j = 0; j < len; j++)
            if (pat_bit(PAT_W - len + j) != pat_bit(j)) ok = 1'b0;
         if (ok) return len;
      end
      return 0;
   endfunction

   localparam logic [SW-1:0] POST_OVL = SW'(border_len());
   localparam logic [SW-1:0] FULL     = SW'(PAT_W);

   logic [SW-1:0] cstate;
   logic [SW-1:0] nstate;
   logic [SW-1:0] ext0 [PAT_W];
   logic [SW-1:0] ext1 [PAT_W];
   logic [SW-1:0] ext_sel;
   logic          match_d;
   logic          out_q, out_d;

   for (genvar k = 0; k < PAT_W; k++) begin : g_tbl
      localparam int unsigned L0 = ext_len(k, 1'b0);
      localparam int unsigned L1 = ext_len(k, 1'b1);
      assign ext0[k] = SW'(L0);
      assign ext1[k] = SW'(L1);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cstate <= '0;
         out_q  <= 1'b0;
      end else begin
         cstate <= nstate;
         out_q  <= out_d;
      end
   end

   // A transition reaching FULL is the match; the FSM lands directly on the post-match state.
   always_comb begin
      ext_sel = '0;
      for (int unsigned k = 0; k < PAT_W; k++)
         if (cstate == SW'(k)) ext_sel = in ? ext1[k] : ext0[k];
      nstate  = cstate;
      match_d = 1'b0;
      if (clr) begin
         nstate = '0;
      end else if (in_valid) begin
         if (ext_sel == FULL) begin
            match_d = 1'b1;
            nstate  = overlap ? POST_OVL : '0;
         end else begin
            nstate = ext_sel;
         end
      end
   end

   always_comb begin
      out_d = match_d;
   end

   assign out = out_q;

`ifdef SEQDET_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (match_d && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign match_cnt = cnt_q;
`else
   assign match_cnt = '0;
`endif

endmodule
